rx_matched_filter: RTL and testbench

Receive-side matched filter paired with the transmit pulse-shaping filter `tx_filter_with_mult`. It takes the 18-bit signed sample stream at the oversampled rate and filters it with a 21-tap symmetric FIR whose coefficients are loaded at run time. It produces a filtered sample every clock, plus a symbol-rate decimated output at a selectable sampling phase. The block sits between the channel/ADC model and the slicer/decision logic.

---
 rtl/rx_matched_filter.sv | 109 ++++++++++
 tb/tb_rx_matched_filter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_matched_filter.sv
// +----------------------------------------------------------------------------+
// | rx_matched_filter: 21-tap symmetric FIR matched filter + symbol decimator  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rx_matched_filter #(
  parameter int DW  = 18,
  parameter int OSR = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_wr,
  input  logic [3:0]           coef_addr,
  input  logic signed [DW-1:0] coef_data,
  input  logic [1:0]           phase_sel,
  output logic signed [DW-1:0] y,
  output logic signed [DW-1:0] y_sym,
  output logic                 sym_valid
);

  localparam int c_taps = 21;
  localparam int c_nc   = 11;
  localparam int c_pw   = DW + 1;
  localparam int c_mw   = 2 * DW + 1;
  localparam int c_sw   = c_mw + 4;
  localparam int c_cw   = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic signed [c_sw-1:0] c_hi = c_sw'(2 ** (DW - 1) - 1);
  localparam logic signed [c_sw-1:0] c_lo = -c_hi - c_sw'(1);

  logic signed [DW-1:0]   r_d    [0:c_taps-1];
  logic signed [DW-1:0]   r_coef [0:c_nc-1];
  logic signed [c_pw-1:0] r_pre  [0:c_nc-1];
  logic signed [c_mw-1:0] r_prod [0:c_nc-1];
  logic signed [c_sw-1:0] r_sum;
  logic [c_cw-1:0]        r_sym_cnt;
  logic [c_cw-1:0]        r_phase_q;

  logic signed [c_sw-1:0] w_sum;
  logic signed [c_sw-1:0] w_shift;
  logic signed [DW-1:0]   w_y;

  // Delay line, coefficient bank, pre-add and multiply stages
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < c_taps; k++) r_d[k] <= '0;
      for (int k = 0; k < c_nc; k++) begin
        r_coef[k] <= '0;
        r_pre[k]  <= '0;
        r_prod[k] <= '0;
      end
    end else begin
      r_d[0] <= x_in;
      for (int k = 1; k < c_taps; k++) r_d[k] <= r_d[k-1];
      if (coef_wr && (coef_addr <= 4'(c_nc - 1))) r_coef[coef_addr] <= coef_data;
      for (int k = 0; k < c_nc - 1; k++)
        r_pre[k] <= c_pw'(r_d[k]) + c_pw'(r_d[c_taps-1-k]);
      r_pre[c_nc-1] <= c_pw'(r_d[c_nc-1]);
      for (int k = 0; k < c_nc; k++)
        r_prod[k] <= c_mw'(r_pre[k]) * c_mw'(r_coef[k]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < c_nc; k++) w_sum = w_sum + c_sw'(r_prod[k]);
  end

  // Floor-scale back to s1.17 and clamp instead of wrapping
  always_comb begin
    w_shift = r_sum >>> (DW - 1);
    w_y     = w_shift[DW-1:0];
    if (w_shift > c_hi)      w_y = c_hi[DW-1:0];
    else if (w_shift < c_lo) w_y = c_lo[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
      y     <= '0;
    end else begin
      r_sum <= w_sum;
      y     <= w_y;
    end
  end

  // Phase only changes at a symbol boundary so each symbol gets exactly one strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym_cnt <= '0;
      r_phase_q <= '0;
      y_sym     <= '0;
      sym_valid <= 1'b0;
    end else begin
      if (r_sym_cnt == c_cw'(OSR - 1)) begin
        r_sym_cnt <= '0;
        r_phase_q <= c_cw'(phase_sel);
      end else begin
        r_sym_cnt <= r_sym_cnt + c_cw'(1);
      end
      sym_valid <= (r_sym_cnt == r_phase_q);
      if (r_sym_cnt == r_phase_q) y_sym <= y;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_matched_filter.sv
// +----------------------------------------------------------------------------+
// | tb_rx_matched_filter: self-checking bench against a convolution model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rx_matched_filter;

  localparam int OSR = 4;

  logic               clk;
  logic               reset;
  logic signed [17:0] x_in;
  logic               coef_wr;
  logic [3:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic [1:0]         phase_sel;
  logic signed [17:0] y;
  logic signed [17:0] y_sym;
  logic               sym_valid;

  int checks   = 0;
  int failures = 0;

  rx_matched_filter #(.DW(18), .OSR(OSR)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .coef_wr(coef_wr),
    .coef_addr(coef_addr), .coef_data(coef_data), .phase_sel(phase_sel),
    .y(y), .y_sym(y_sym), .sym_valid(sym_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: input history (index 0 = newest), coefficient snapshots per edge
  longint xh [25];
  longint cm [11];
  longint ch [4][11];
  int     t;
  int     phq;
  longint exp_y, exp_ysym;
  bit     exp_valid;
  bit     model_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic longint sat18(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic model_edge();
    longint acc;
    bit vld;
    if (reset) begin
      foreach (xh[i]) xh[i] = 0;
      foreach (cm[i]) cm[i] = 0;
      for (int s = 0; s < 4; s++) for (int i = 0; i < 11; i++) ch[s][i] = 0;
      t = 0; phq = 0;
      exp_y = 0; exp_ysym = 0; exp_valid = 1'b0;
      model_on = 1'b1;
    end else begin
      t++;
      vld = (((t - 1) % OSR) == phq);
      if (vld) exp_ysym = exp_y;
      exp_valid = vld;
      if (((t - 1) % OSR) == OSR - 1) phq = int'(phase_sel);
      for (int i = 24; i > 0; i--) xh[i] = xh[i-1];
      xh[0] = longint'(x_in);
      if (coef_wr && coef_addr <= 10) cm[coef_addr] = longint'(coef_data);
      for (int s = 3; s > 0; s--) for (int i = 0; i < 11; i++) ch[s][i] = ch[s-1][i];
      for (int i = 0; i < 11; i++) ch[0][i] = cm[i];
      acc = 0;
      for (int k = 0; k < 21; k++) acc += xh[4+k] * ch[3][(k <= 10) ? k : 20 - k];
      exp_y = sat18(acc >>> 17);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input longint xv);
    for (int i = 0; i < n; i++) begin
      x_in = 18'(xv); coef_wr = 1'b0;
      step();
    end
  endtask

  task automatic wr_coef(input int a, input longint v);
    coef_wr = 1'b1; coef_addr = 4'(a); coef_data = 18'(v); x_in = '0;
    step();
    coef_wr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("y", longint'(y), exp_y);
      chk("y_sym", longint'(y_sym), exp_ysym);
      chk("sym_valid", longint'(sym_valid), longint'(exp_valid));
    end
  end

  initial begin
    int pulses;
    reset = 1'b1; x_in = '0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0; phase_sel = 2'd0;
    #2;
    for (int i = 0; i < 3; i++) step();
    chk("reset_y", longint'(y), 0);
    chk("reset_y_sym", longint'(y_sym), 0);
    chk("reset_sym_valid", longint'(sym_valid), 0);
    reset = 1'b0;

    // Impulse response with c[k] = 1000*(k+1)
    for (int k = 0; k < 11; k++) wr_coef(k, 1000 * (k + 1));
    idle(1, 65536);
    idle(3, 0);
    for (int i = 0; i < 21; i++) begin
      idle(1, 0);
      chk("impulse", longint'(y), 500 * (((i <= 10) ? i : 20 - i) + 1));
    end
    idle(1, 0);
    chk("impulse_tail", longint'(y), 0);

    // Coefficient reload of the centre tap under constant input
    idle(30, 65536);
    chk("dc_level", longint'(y), 60500);
    coef_wr = 1'b1; coef_addr = 4'd10; coef_data = '0; x_in = 18'sd65536;
    step();
    coef_wr = 1'b0;
    idle(1, 65536);
    chk("reload_w1", longint'(y), 60500);
    idle(1, 65536);
    chk("reload_w2", longint'(y), 60500);
    idle(1, 65536);
    chk("reload_w3", longint'(y), 55000);
    coef_wr = 1'b1; coef_addr = 4'd12; coef_data = 18'sd77777; x_in = 18'sd65536;
    step();
    coef_wr = 1'b0;
    idle(6, 65536);
    chk("addr12_ignored", longint'(y), 55000);

    // Decimation with a ramp, phase 2 then a mid-symbol switch to 1
    phase_sel = 2'd2;
    for (int i = 0; i < 8; i++) idle(1, i * 500);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1, 4000 + i * 500);
      if (sym_valid) pulses++;
    end
    chk("pulses_per_16", pulses, 4);
    idle(int'($urandom_range(1, 3)), 12000);
    phase_sel = 2'd1;
    for (int i = 0; i < 24; i++) idle(1, 12000 + i * 500);

    // Reset during an impulse response
    idle(25, 0);
    idle(1, 65536);
    idle(8, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_y", longint'(y), 0);
    chk("midreset_y_sym", longint'(y_sym), 0);
    chk("midreset_sym_valid", longint'(sym_valid), 0);
    idle(12, 65536);
    chk("post_reset_cleared_coef", longint'(y), 0);

    // Saturation
    for (int k = 0; k < 11; k++) wr_coef(k, 131071);
    idle(30, 131071);
    chk("sat_pos", longint'(y), 131071);
    idle(30, -131072);
    chk("sat_neg", longint'(y), -131072);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      x_in      = 18'($urandom_range(0, 262143));
      coef_wr   = ($urandom_range(0, 7) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = 18'($urandom_range(0, 262143));
      if ($urandom_range(0, 9) == 0) phase_sel = 2'($urandom_range(0, 3));
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; coef_wr = 1'b0;
    idle(4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
